// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring shift-subtract
// iterations plus one sign fix-up cycle, one operation in flight.
module muldiv_unit #(
  parameter int WORDSIZE = 32,
  parameter int ADDRSIZE = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] rs1Data,
  input  logic [WORDSIZE-1:0] rs2Data,
  input  logic [ADDRSIZE-1:0] rdAddr,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] writeData,
  output logic [ADDRSIZE-1:0] writeReg,
  output logic                regWrite
);

  localparam int CW = $clog2(WORDSIZE);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                state, stateNext;
  logic [CW-1:0]         counter;
  logic [2:0]            opSel;
  logic [ADDRSIZE-1:0]   rdLatch;
  logic [WORDSIZE-1:0]   opA, opB, accHi, accLo;
  logic                  negRes, negRem, divZero;

  logic                  signed1, signed2, neg1, neg2;
  logic [WORDSIZE-1:0]   mag1, mag2;
  logic [WORDSIZE:0]     mulSum, divShift;
  logic                  divFits;
  logic [WORDSIZE-1:0]   divDiff;
  logic [2*WORDSIZE-1:0] prodMag, prodFix;
  logic [WORDSIZE-1:0]   quoFix, remFix, result;

  // Operand magnitudes and signs, captured only on the accepting edge.
  always_comb begin
    signed1 = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    signed2 = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    neg1    = signed1 && rs1Data[WORDSIZE-1];
    neg2    = signed2 && rs2Data[WORDSIZE-1];
    mag1    = neg1 ? -rs1Data : rs1Data;
    mag2    = neg2 ? -rs2Data : rs2Data;
  end

  // Multiply: {accHi,accLo} is the product register with the multiplier in accLo.
  // Divide: accHi is the partial remainder, accLo shifts dividend out and quotient in.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
    divShift = {accHi, accLo[WORDSIZE-1]};
    divFits  = divShift >= {1'b0, opB};
    divDiff  = divShift[WORDSIZE-1:0] - opB;
  end

  always_comb begin
    prodMag = {accHi, accLo};
    prodFix = negRes ? -prodMag : prodMag;
    // A zero divisor yields all-ones regardless of operand signs.
    quoFix  = divZero ? '1 : (negRes ? -accLo : accLo);
    remFix  = negRem ? -accHi : accHi;
    case (opSel)
      3'd0:                result = prodFix[WORDSIZE-1:0];
      3'd1, 3'd2, 3'd3:    result = prodFix[2*WORDSIZE-1:WORDSIZE];
      3'd4, 3'd5:          result = quoFix;
      default:             result = remFix;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (counter == CW'(WORDSIZE - 1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter   <= '0;
      opSel     <= '0;
      rdLatch   <= '0;
      opA       <= '0;
      opB       <= '0;
      accHi     <= '0;
      accLo     <= '0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      done      <= 1'b0;
      regWrite  <= 1'b0;
      writeData <= '0;
      writeReg  <= '0;
    end else begin
      done     <= 1'b0;
      regWrite <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opSel   <= funct3;
          rdLatch <= rdAddr;
          opA     <= mag1;
          opB     <= mag2;
          accHi   <= '0;
          accLo   <= funct3[2] ? mag1 : mag2;
          negRes  <= neg1 ^ neg2;
          negRem  <= neg1;
          divZero <= (rs2Data == '0);
          counter <= '0;
        end
        CALC: begin
          counter <= counter + CW'(1);
          if (opSel[2]) begin
            accHi <= divFits ? divDiff : divShift[WORDSIZE-1:0];
            accLo <= {accLo[WORDSIZE-2:0], divFits};
          end else begin
            accHi <= mulSum[WORDSIZE:1];
            accLo <= {mulSum[0], accLo[WORDSIZE-1:1]};
          end
        end
        FIX: begin
          writeData <= result;
          writeReg  <= rdLatch;
          done      <= 1'b1;
          regWrite  <= (rdLatch != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver pushes expected {writeReg,regWrite,writeData}
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1Data = '0;
  logic [31:0] rs2Data = '0;
  logic [4:0]  rdAddr = '0;
  logic        busy, done, regWrite;
  logic [31:0] writeData;
  logic [4:0]  writeReg;

  logic [37:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WORDSIZE(32), .ADDRSIZE(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddr(rdAddr),
    .busy(busy), .done(done), .writeData(writeData),
    .writeReg(writeReg), .regWrite(regWrite)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("result {reg,we,data}", 64'({writeReg, regWrite, writeData}), 64'(e));
      end
    end
  end

  // Driver: call at a negedge; returns at the negedge where done is visible.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int glitch_cyc);
    int lat;
    funct3  = f;
    rs1Data = a;
    rs2Data = b;
    rdAddr  = rd;
    start   = 1'b1;
    exp_q.push_back({rd, (rd != 5'd0), exp});
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    rs1Data = $urandom;
    rs2Data = $urandom;
    funct3  = 3'($urandom_range(0, 7));
    rdAddr  = 5'($urandom_range(0, 31));
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (lat == glitch_cyc);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'd34);
  endtask

  initial begin
    int wait_cyc;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_writeData", 64'(writeData), 64'd0);
    check("rst_writeReg", 64'(writeReg), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // MUL with one-cycle done/regWrite pulse
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 0);
    @(negedge clk);
    check("done_pulse_end", 64'(done), 64'd0);
    check("regWrite_pulse_end", 64'(regWrite), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);

    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 0);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5'd19, 32'hFFFFFFFF, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 0);
    run_op(3'd5, 32'h64, 32'd7, 5'd11, 32'h0000000E, 0);
    run_op(3'd7, 32'h64, 32'd7, 5'd12, 32'h00000002, 0);
    // Divide by zero and signed overflow
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 0);
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd0, 5'd20, 32'hFFFFFFFF, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd0, 5'd21, 32'hFFFFFFF9, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 0);
    // x0 destination: done without regWrite
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 0);
    @(negedge clk);

    // Start while busy ignored; start in the done cycle accepted
    run_op(3'd0, 32'd9, 32'd11, 5'd17, 32'd99, 10);
    run_op(3'd5, 32'd1000, 32'd3, 5'd18, 32'd333, 0);
    @(negedge clk);

    // Reset mid-divide: op discarded, outputs cleared
    funct3 = 3'd4; rs1Data = 32'd500; rs2Data = 32'd7; rdAddr = 5'd22;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_writeData", 64'(writeData), 64'd0);
    check("abort_writeReg", 64'(writeReg), 64'd0);
    repeat (40) @(negedge clk);
    run_op(3'd4, 32'hFFFFFF9C, 32'd7, 5'd23, 32'hFFFFFFF2, 0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
